// File: rtl/qspi_page_programmer.sv
// Programs an image into QSPI NOR flash one 256-byte page at a time, erasing
// each 64 KiB-class sector before its first page by driving a command-level controller.
module qspi_page_programmer #(
   parameter int SECTOR_BITS = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [23:0]   base_addr,
   input  logic [15:0]   num_pages,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          ctrl_trigger,
   output logic [7:0]    ctrl_cmd,
   output logic [2071:0] ctrl_data_send,
   input  logic          ctrl_busy,
   input  logic          ctrl_error,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [15:0]   pages_done
);

   localparam logic [7:0] CMD_WREN = 8'h06;
   localparam logic [7:0] CMD_SE   = 8'hD8;
   localparam logic [7:0] CMD_PP   = 8'h02;

   typedef enum logic [3:0] {
      S_IDLE, S_CHECK, S_FILL, S_WREN_SE, S_SE, S_WREN_PP,
      S_PP, S_ISSUE, S_ACK, S_WAITC, S_NEXT, S_FIN
   } state_t;

   state_t          r_state;
   state_t          w_next;
   state_t          r_ret;

   logic [23:0]     r_addr;
   logic [15:0]     r_num_pages;
   logic [15:0]     r_pages_done;
   logic [7:0]      r_byte_cnt;
   logic [2047:0]   r_page_buf;
   logic [7:0]      r_cmd;
   logic [2071:0]   r_data_send;
   logic            r_busy;
   logic            r_error;

   logic [23:0]     w_base_page;
   logic            w_accept;
   logic            w_xfer;
   logic            w_sector_start;
   logic            w_cmd_fail;

   assign w_base_page    = base_addr & 24'hFFFF00;
   assign w_accept       = (r_state == S_IDLE) && start && !ctrl_busy;
   assign w_xfer         = (r_state == S_FILL) && in_valid;
   assign w_sector_start = (r_addr[SECTOR_BITS-1:0] == '0);
   // Only erase and program report meaningful failure status.
   assign w_cmd_fail     = ((r_cmd == CMD_SE) || (r_cmd == CMD_PP)) && ctrl_error;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_CHECK;
         end
         S_CHECK: begin
            if (r_pages_done == r_num_pages)
               w_next = S_FIN;
            else if ((r_pages_done == 16'd0) || w_sector_start)
               w_next = S_WREN_SE;
            else
               w_next = S_FILL;
         end
         S_FILL: begin
            if (in_valid && (r_byte_cnt == 8'hFF)) w_next = S_WREN_PP;
         end
         S_WREN_SE, S_SE, S_WREN_PP, S_PP: w_next = S_ISSUE;
         S_ISSUE: w_next = S_ACK;
         // Controller may not have raised busy yet, so give it one cycle.
         S_ACK:   w_next = S_WAITC;
         S_WAITC: begin
            if (!ctrl_busy) w_next = w_cmd_fail ? S_FIN : r_ret;
         end
         S_NEXT:  w_next = S_CHECK;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready     = (r_state == S_FILL);
      ctrl_trigger = (r_state == S_ISSUE);
      done         = (r_state == S_FIN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy       <= 1'b0;
         r_error      <= 1'b0;
         r_pages_done <= '0;
         r_byte_cnt   <= '0;
         r_cmd        <= '0;
         r_data_send  <= '0;
         r_ret        <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_busy       <= 1'b1;
                  r_error      <= 1'b0;
                  r_pages_done <= '0;
                  r_byte_cnt   <= '0;
               end
            end
            S_FILL: begin
               if (in_valid) r_byte_cnt <= r_byte_cnt + 8'd1;
            end
            S_WREN_SE: begin
               r_cmd       <= CMD_WREN;
               r_data_send <= '0;
               r_ret       <= S_SE;
            end
            S_SE: begin
               r_cmd       <= CMD_SE;
               r_data_send <= {2048'b0, r_addr};
               r_ret       <= S_FILL;
            end
            S_WREN_PP: begin
               r_cmd       <= CMD_WREN;
               r_data_send <= '0;
               r_ret       <= S_PP;
            end
            S_PP: begin
               r_cmd       <= CMD_PP;
               r_data_send <= {r_addr, r_page_buf};
               r_ret       <= S_NEXT;
            end
            S_WAITC: begin
               if (!ctrl_busy && w_cmd_fail) r_error <= 1'b1;
            end
            S_NEXT: r_pages_done <= r_pages_done + 16'd1;
            S_FIN:  r_busy <= 1'b0;
            default: ;
         endcase
      end
   end

   // Job parameters and page data need no reset: they are loaded before use.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr      <= w_base_page;
         r_num_pages <= num_pages;
      end else if (r_state == S_NEXT) begin
         r_addr <= r_addr + 24'd256;
      end
      if (w_xfer) r_page_buf <= {r_page_buf[2039:0], in_data};
   end

   assign ctrl_cmd       = r_cmd;
   assign ctrl_data_send = r_data_send;
   assign busy           = r_busy;
   assign error          = r_error;
   assign pages_done     = r_pages_done;

endmodule

// File: tb/tb_qspi_page_programmer.sv
// Directed + randomized bench for qspi_page_programmer with a behavioural
// flash-controller responder and a command-list reference model.
module tb_qspi_page_programmer;

   localparam int SB = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [23:0]   base_addr = '0;
   logic [15:0]   num_pages = '0;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          ctrl_trigger;
   logic [7:0]    ctrl_cmd;
   logic [2071:0] ctrl_data_send;
   logic          ctrl_busy;
   logic          ctrl_error;
   logic          busy;
   logic          done;
   logic          error;
   logic [15:0]   pages_done;

   always #5 clk = ~clk;

   qspi_page_programmer #(.SECTOR_BITS(SB)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .num_pages(num_pages), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .ctrl_trigger(ctrl_trigger), .ctrl_cmd(ctrl_cmd),
      .ctrl_data_send(ctrl_data_send), .ctrl_busy(ctrl_busy),
      .ctrl_error(ctrl_error), .busy(busy), .done(done), .error(error),
      .pages_done(pages_done)
   );

   int checks = 0;
   int failures = 0;

   logic [7:0]    img [0:1023];
   int            idx = 0;
   int            vmode = 0;
   logic [7:0]    log_cmd [$];
   logic [2071:0] log_data [$];
   int            err_idx = -1;
   int            busy_fix = 0;
   bit            hold_busy = 1'b0;

   logic [7:0]    exp_cmd [$];
   logic [2071:0] exp_data [$];
   int            exp_pages;
   int            exp_err;
   int            exp_bytes;

   // Controller responder: logs each command, stays busy a few cycles,
   // and flags an error on completion of the selected command.
   initial begin
      int cnt;
      bit cb;
      cnt = 0; cb = 1'b0;
      ctrl_busy = 1'b0; ctrl_error = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            cnt = 0; cb = 1'b0; ctrl_error = 1'b0;
         end else if (ctrl_trigger) begin
            log_cmd.push_back(ctrl_cmd);
            log_data.push_back(ctrl_data_send);
            cnt = (busy_fix > 0) ? busy_fix : int'($urandom_range(1, 4));
            cb = 1'b1; ctrl_error = 1'b0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               cb = 1'b0;
               ctrl_error = ((log_cmd.size() - 1) == err_idx);
            end
         end
         ctrl_busy = cb | hold_busy;
      end
   end

   // Byte source: a transfer happens at the next edge when both are high now.
   initial begin
      in_valid = 1'b0; in_data = '0;
      forever begin
         @(negedge clk);
         case (vmode)
            0: in_valid = 1'b1;
            1: in_valid = ~in_valid;
            default: in_valid = ($urandom_range(0, 3) != 0);
         endcase
         in_data = img[idx % 1024];
         if (in_valid && in_ready) idx++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wide(input string tag, input logic [2071:0] obs, input logic [2071:0] exp);
      int bad;
      logic [7:0] ob, eb;
      bad = 0; ob = '0; eb = '0;
      for (int i = 258; i >= 0; i--) begin
         if (obs[8*i +: 8] !== exp[8*i +: 8]) begin
            bad = i; ob = obs[8*i +: 8]; eb = exp[8*i +: 8];
         end
      end
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: byte_lane %0d observed=%02h expected=%02h", tag, bad, ob, eb);
      end
   endtask

   // Reference: walk the pages with plain address arithmetic.
   task automatic build_model(input logic [23:0] base, input int n, input int err_page);
      logic [23:0]   a;
      logic [2071:0] d;
      exp_cmd.delete(); exp_data.delete();
      err_idx = -1; exp_pages = 0; exp_err = 0; exp_bytes = 0;
      a = {base[23:8], 8'h00};
      for (int p = 0; p < n; p++) begin
         if (p == 0 || (int'(a) % (1 << SB)) == 0) begin
            exp_cmd.push_back(8'h06); exp_data.push_back('0);
            d = '0; d[23:0] = a;
            exp_cmd.push_back(8'hD8); exp_data.push_back(d);
         end
         exp_bytes += 256;
         d = '0;
         d[2071:2048] = a;
         for (int i = 0; i < 256; i++) d[2047 - 8*i -: 8] = img[p*256 + i];
         exp_cmd.push_back(8'h06); exp_data.push_back('0);
         exp_cmd.push_back(8'h02); exp_data.push_back(d);
         if (p == err_page) begin
            err_idx = exp_cmd.size() - 1;
            exp_err = 1;
            break;
         end
         exp_pages++;
         a = a + 24'd256;
      end
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_ncmd"}, 64'(log_cmd.size()), 64'(exp_cmd.size()));
      for (int i = 0; i < exp_cmd.size() && i < log_cmd.size(); i++) begin
         chk($sformatf("%s_cmd%0d", tag, i), 64'(log_cmd[i]), 64'(exp_cmd[i]));
         if (exp_cmd[i] == 8'hD8)
            chk($sformatf("%s_se_addr%0d", tag, i), 64'(log_data[i][23:0]), 64'(exp_data[i][23:0]));
         else if (exp_cmd[i] == 8'h02)
            chk_wide($sformatf("%s_pp%0d", tag, i), log_data[i], exp_data[i]);
      end
   endtask

   task automatic run_job(input string tag, input logic [23:0] base, input int n,
                          input int err_page, input int mode, input bit pat,
                          input bit extra, output int lat);
      int dcnt;
      bit finished;
      for (int i = 0; i < 1024; i++) img[i] = pat ? 8'(i) : 8'($urandom);
      build_model(base, n, err_page);
      vmode = mode; idx = 0;
      log_cmd.delete(); log_data.delete();
      @(negedge clk);
      start = 1'b1; base_addr = base; num_pages = 16'(n);
      @(negedge clk);
      start = 1'b0; base_addr = 24'($urandom); num_pages = 16'($urandom);
      dcnt = 0; finished = 1'b0; lat = -1;
      for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
         if (done) begin
            dcnt++; finished = 1'b1; lat = cyc;
         end else begin
            if (extra && cyc == 40) begin
               start = 1'b1; base_addr = 24'h500000; num_pages = 16'd7;
            end
            if (extra && cyc == 41) start = 1'b0;
            @(negedge clk);
         end
      end
      chk({tag, "_finished"}, 64'(finished), 64'd1);
      repeat (3) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk({tag, "_done_cnt"}, 64'(dcnt), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_pages_done"}, 64'(pages_done), 64'(exp_pages));
      chk({tag, "_error"}, 64'(error), 64'(exp_err));
      chk({tag, "_bytes"}, 64'(idx), 64'(exp_bytes));
      check_log(tag);
   endtask

   initial begin
      int lat;
      int cnt_before;

      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_pages", 64'(pages_done), 64'd0);
      chk("rst_trigger", 64'(ctrl_trigger), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_cmd", 64'(ctrl_cmd), 64'd0);
      chk("rst_data_zero", 64'(ctrl_data_send === '0), 64'd1);
      reset = 1'b0;
      @(negedge clk);

      run_job("two_pages", 24'h010000, 2, -1, 0, 1'b1, 1'b0, lat);
      run_job("sector_cross", 24'h01FF00, 2, -1, 2, 1'b0, 1'b0, lat);
      run_job("pp_error", 24'h020000, 3, 0, 0, 1'b0, 1'b0, lat);
      run_job("toggle_valid", 24'h0400A5, 1, -1, 1, 1'b0, 1'b0, lat);
      run_job("zero_pages", 24'h123400, 0, -1, 0, 1'b0, 1'b0, lat);
      chk("zero_pages_latency", 64'((lat >= 0) && (lat <= 4)), 64'd1);
      run_job("addr_wrap", 24'hFFFF00, 2, -1, 2, 1'b0, 1'b0, lat);
      run_job("start_while_busy", 24'h05FE00, 2, -1, 0, 1'b0, 1'b1, lat);
      run_job("pp_error_mid", 24'h070000, 3, 1, 2, 1'b0, 1'b0, lat);
      for (int j = 0; j < 3; j++)
         run_job($sformatf("rand%0d", j), 24'($urandom), int'($urandom_range(1, 3)),
                 -1, 2, 1'b0, 1'b0, lat);

      // Start is refused while the controller reports busy.
      log_cmd.delete(); log_data.delete();
      hold_busy = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b1; base_addr = 24'h080000; num_pages = 16'd1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("ctrl_busy_start_busy", 64'(busy), 64'd0);
      hold_busy = 1'b0;
      repeat (5) @(negedge clk);
      chk("ctrl_busy_start_idle", 64'(busy), 64'd0);
      chk("ctrl_busy_start_ncmd", 64'(log_cmd.size()), 64'd0);

      // Reset while waiting on the controller for the sector erase.
      for (int i = 0; i < 1024; i++) img[i] = 8'($urandom);
      busy_fix = 6; vmode = 0; idx = 0; err_idx = -1;
      log_cmd.delete(); log_data.delete();
      start = 1'b1; base_addr = 24'h030000; num_pages = 16'd2;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 200 && log_cmd.size() < 2; c++) @(negedge clk);
      chk("wc_reached", 64'(log_cmd.size()), 64'd2);
      chk("wc_is_se", 64'(log_cmd.size() >= 2 ? log_cmd[1] : 8'h00), 64'hD8);
      repeat (2) @(negedge clk);
      chk("wc_busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("wc_rst_busy", 64'(busy), 64'd0);
      chk("wc_rst_done", 64'(done), 64'd0);
      chk("wc_rst_error", 64'(error), 64'd0);
      chk("wc_rst_pages", 64'(pages_done), 64'd0);
      chk("wc_rst_trigger", 64'(ctrl_trigger), 64'd0);
      chk("wc_rst_in_ready", 64'(in_ready), 64'd0);
      chk("wc_rst_cmd", 64'(ctrl_cmd), 64'd0);
      chk("wc_rst_data_zero", 64'(ctrl_data_send === '0), 64'd1);
      reset = 1'b0; busy_fix = 0;
      cnt_before = log_cmd.size();
      repeat (30) @(negedge clk);
      chk("wc_no_more_trig", 64'(log_cmd.size()), 64'(cnt_before));
      chk("wc_idle_busy", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/qspi_page_programmer.md
QSPI_PAGE_PROGRAMMER -- requirements
Module: qspi_page_programmer

Interface
REQ-001 Parameter SECTOR_BITS, default 16, log2 of erase-sector size in bytes (64 KiB).
REQ-002 clk  input  1  clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 start  input  1  one-cycle request to program an image; ignored while busy=1.
REQ-005 base_addr  input  24  first flash byte address, page-aligned (low 8 bits ignored, treated as 0); latched on accepted start.
REQ-006 num_pages  input  16  number of 256-byte pages to write; latched on accepted start.
REQ-007 in_data  input  8  image byte stream, lowest flash address first.
REQ-008 in_valid / in_ready  input / output  1 / 1  byte transfers when both are 1 on a clock edge.
REQ-009 ctrl_trigger  output  1  command strobe to the QSPI memory controller.
REQ-010 ctrl_cmd  output  8  command: WREN 0x06, SE 0xD8, PP 0x02.
REQ-011 ctrl_data_send  output  2072  SE: bits[23:0]=address; PP: bits[2071:2048]=address, bits[2047:0]=page, first byte in bits[2047:2040].
REQ-012 ctrl_busy, ctrl_error  input  1, 1  controller busy and error flags.
REQ-013 busy  output  1  job in progress.
REQ-014 done  output  1  one-cycle pulse at job end.
REQ-015 error  output  1  sticky job-failed flag; cleared on accepted start.
REQ-016 pages_done  output  16  pages successfully programmed in the current job.

Function
REQ-017 States: IDLE, CHECK, FILL, WREN_SE, SE, WREN_PP, PP, ISSUE, ACK, WAITC, NEXT, FIN.
REQ-018 IDLE: start=1 and ctrl_busy=0 -> latch inputs, addr:={base_addr[23:8],8'h00}, pages_done:=0, error:=0, busy:=1, go CHECK; start while ctrl_busy=1 is ignored.
REQ-019 CHECK: pages_done==num_pages -> FIN; else if first page of job or addr[SECTOR_BITS-1:0]==0 -> WREN_SE; else FILL.
REQ-020 WREN_SE/SE/WREN_PP/PP set ctrl_cmd and ctrl_data_send, store return state, go ISSUE; returns: WREN_SE->SE, SE->FILL, WREN_PP->PP, PP->NEXT.
REQ-021 ISSUE: ctrl_trigger=1 for exactly this one cycle; next state ACK.
REQ-022 ACK: one cycle, ctrl_busy ignored; next state WAITC.
REQ-023 WAITC: stay while ctrl_busy=1; on ctrl_busy=0: if command was SE or PP and ctrl_error=1 -> error:=1, go FIN; else go to return state.
REQ-024 ctrl_cmd and ctrl_data_send hold stable from ISSUE until the next command is loaded.
REQ-025 FILL: in_ready=1; each transfer shifts page_buf left 8 bits with in_data entering bits[7:0]; byte counter 0..255; on 256th transfer in_ready drops the next cycle and state -> WREN_PP.
REQ-026 in_ready=0 in every state except FILL; no byte is lost or duplicated when in_valid toggles.
REQ-027 NEXT: pages_done+=1, addr+=256 (24-bit wrap, 0xFFFF00 -> 0x000000 and the wrapped page triggers SE), -> CHECK.
REQ-028 FIN: done=1 for one cycle, busy:=0, -> IDLE; error and pages_done hold until next start.
REQ-029 num_pages=0 -> no controller command issued, done pulse, error=0.
REQ-030 Sector erase occurs once per sector touched, before its first page; unaligned job start erases the containing sector (address = addr, low SECTOR_BITS not cleared; controller/flash ignore them).

Reset
REQ-031 reset: state IDLE, busy=0, done=0, error=0, pages_done=0, ctrl_trigger=0, in_ready=0, byte counter 0; ctrl_cmd/ctrl_data_send 0.
REQ-032 reset mid-job aborts immediately without further triggers; the controller is reset by the same signal.

Verification
REQ-033 base_addr=0x010000, num_pages=2, 512 bytes 0x00..0xFF x2 -> command order WREN,SE(0x010000),WREN,PP(0x010000),WREN,PP(0x010100); done once, pages_done=2, error=0.
REQ-034 base_addr=0x01FF00, num_pages=2 -> SE 0x01FF00, PP 0x01FF00, then WREN,SE 0x020000, WREN,PP 0x020000.
REQ-035 PP with ctrl_error=1 on busy fall for page 1 of 3 -> error=1, pages_done=0, done pulse, no further triggers.
REQ-036 in_valid toggling every other cycle during FILL -> PP data bits[2047:2040]=first byte, bits[7:0]=256th byte, exactly 256 accepted.
REQ-037 num_pages=0 -> done within 4 cycles, zero ctrl_trigger pulses; start during busy ignored; reset during WAITC -> all outputs at reset values next cycle.
